// File: rtl/ysyx_22040125_mdu.sv
// ysyx_22040125_mdu: iterative RV64M multiply/divide unit, one bit per cycle.
// Ports: clk, rst (sync, high), flush; in_valid/in_ready with op/word/src1/src2;
// out_valid/out_ready with result; busy. Option macro: MDU_FAST_MUL_EN.
module ysyx_22040125_mdu #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int IW    = $clog2(XLEN);
  localparam bit HAS_W = (XLEN == 64);
  localparam int PW    = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_r;
  logic             wd_r;
  logic             neg1_r;
  logic             neg2_r;
  logic [XLEN-1:0]  a;
  logic [XLEN-1:0]  b;
  logic [XLEN-1:0]  q;
  logic [XLEN-1:0]  rem;
  logic [PW-1:0]    acc;

  function automatic logic [XLEN-1:0] sx32(
    input logic [XLEN-1:0] v
  );
    return XLEN'($signed(v[31:0]));
  endfunction

  function automatic logic [XLEN-1:0] mul_sel(
    input logic [PW-1:0] p,
    input logic          w,
    input logic [1:0]    f
  );
    logic [XLEN-1:0] r;
    r = (w || f == 2'b00) ? p[XLEN-1:0] : p[PW-1:XLEN];
    return w ? sx32(r) : r;
  endfunction

  logic            wd;
  logic            sg1;
  logic            sg2;
  logic            n1;
  logic            n2;
  logic            dz;
  logic            ovf;
  logic [XLEN-1:0] msk;
  logic [XLEN-1:0] minv;
  logic [XLEN-1:0] x1;
  logic [XLEN-1:0] x2;
  logic [XLEN-1:0] m1;
  logic [XLEN-1:0] m2;
  logic [XLEN-1:0] sq;
  logic [XLEN-1:0] sr;
  logic [XLEN-1:0] ssel;

  assign wd   = word & HAS_W;
  assign msk  = wd ? XLEN'(32'hFFFF_FFFF) : '1;
  assign minv = wd ? XLEN'(32'h8000_0000) : (XLEN'(1) << (XLEN - 1));

  // Only MULH/MULHSU and signed divide see signed operands; the low
  // product half is sign-agnostic, so MUL/MULW run unsigned.
  always_comb begin
    sg1 = 1'b0;
    sg2 = 1'b0;
    if (op[2]) begin
      sg1 = ~op[0];
      sg2 = ~op[0];
    end else if (!wd) begin
      sg1 = op[1] ^ op[0];
      sg2 = (op[1:0] == 2'b01);
    end
  end

  assign x1 = src1 & msk;
  assign x2 = src2 & msk;
  assign n1 = sg1 & (wd ? src1[31] : src1[XLEN-1]);
  assign n2 = sg2 & (wd ? src2[31] : src2[XLEN-1]);
  assign m1 = (n1 ? -x1 : x1) & msk;
  assign m2 = (n2 ? -x2 : x2) & msk;

  assign dz   = op[2] & (x2 == '0);
  assign ovf  = op[2] & ~op[0] & (x1 == minv) & (x2 == msk);
  assign sq   = dz ? msk : x1;
  assign sr   = dz ? x1 : '0;
  assign ssel = op[1] ? sr : sq;

`ifdef MDU_FAST_MUL_EN
  logic [PW-1:0] fp;
  assign fp = {{XLEN{sg1 & src1[XLEN-1]}}, x1}
            * {{XLEN{sg2 & src2[XLEN-1]}}, x2};
`endif

  logic [IW-1:0]   bi;
  logic [XLEN:0]   rs;
  logic            qb;
  logic [PW-1:0]   acc_nx;
  logic [PW-1:0]   p;
  logic [XLEN-1:0] q_nx;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] qf;
  logic [XLEN-1:0] rf;
  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] fres;

  // The counter doubles as the operand bit index, MSB first.
  assign bi = cnt[IW-1:0];

  always_comb begin
    acc_nx = {acc[PW-2:0], 1'b0} + (b[bi] ? PW'(a) : '0);
    rs     = {rem, a[bi]};
    qb     = (rs >= {1'b0, b});
    rem_nx = qb ? XLEN'(rs - {1'b0, b}) : rs[XLEN-1:0];
    q_nx   = {q[XLEN-2:0], qb};
    p      = (neg1_r ^ neg2_r) ? -acc_nx : acc_nx;
    qf     = (neg1_r ^ neg2_r) ? -q_nx : q_nx;
    rf     = neg1_r ? -rem_nx : rem_nx;
    raw    = op_r[1] ? rf : qf;
    if (!op_r[2]) begin
      fres = mul_sel(p, wd_r, op_r[1:0]);
    end else begin
      fres = wd_r ? sx32(raw) : raw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      result <= '0;
      cnt    <= '0;
    end else if (flush) begin
      st <= IDLE;
    end else begin
      unique case (st)
        IDLE: if (in_valid) begin
          op_r   <= op;
          wd_r   <= wd;
          neg1_r <= n1;
          neg2_r <= n2;
          a      <= m1;
          b      <= m2;
          acc    <= '0;
          q      <= '0;
          rem    <= '0;
          cnt    <= wd ? CNT_W'(31) : CNT_W'(XLEN - 1);
          if (dz | ovf) begin
            result <= wd ? sx32(ssel) : ssel;
            st     <= DONE;
          end
`ifdef MDU_FAST_MUL_EN
          else if (!op[2]) begin
            result <= mul_sel(fp, wd, op[1:0]);
            st     <= DONE;
          end
`endif
          else begin
            st <= CALC;
          end
        end
        CALC: begin
          acc <= acc_nx;
          q   <= q_nx;
          rem <= rem_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            result <= fres;
            st     <= DONE;
          end
        end
        DONE: if (out_ready) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  assign in_ready  = (st == IDLE) & ~flush;
  assign out_valid = (st == DONE);
  assign busy      = (st != IDLE);

endmodule

// File: tb/tb_ysyx_22040125_mdu.sv
// tb_ysyx_22040125_mdu: vector table, corner sequences and random ops
// against an arithmetic reference model of the RV64M unit.
module tb_ysyx_22040125_mdu;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

`ifdef MDU_FAST_MUL_EN
  localparam int MLAT  = 1;
  localparam int MLATW = 1;
`else
  localparam int MLAT  = 64;
  localparam int MLATW = 32;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic        word;
  logic [63:0] src1;
  logic [63:0] src2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ysyx_22040125_mdu #(.XLEN(64), .CNT_W(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .word      (word),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    int          lat;
  } vec_t;

  vec_t tv[16];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [2:0] o,
    input logic w, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sp;
    logic [127:0]        up;
    logic signed [63:0]  sa;
    logic signed [63:0]  sb;
    logic signed [31:0]  ha;
    logic signed [31:0]  hb;
    logic [31:0]         r32;
    logic [63:0]         r;
    sa = a;
    sb = b;
    ha = a[31:0];
    hb = b[31:0];
    r32 = '0;
    r = '0;
    if (w) begin
      if (!o[2]) r32 = a[31:0] * b[31:0];
      else if (b[31:0] == 0) r32 = o[1] ? a[31:0] : 32'hFFFF_FFFF;
      else if (!o[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
        r32 = o[1] ? 32'd0 : a[31:0];
      else if (o[1:0] == 2'b00) r32 = ha / hb;
      else if (o[1:0] == 2'b01) r32 = a[31:0] / b[31:0];
      else if (o[1:0] == 2'b10) r32 = ha % hb;
      else r32 = a[31:0] % b[31:0];
      r = {{32{r32[31]}}, r32};
    end else if (!o[2]) begin
      if (o[1:0] == 2'b00) r = a * b;
      else if (o[1:0] == 2'b01) begin
        sp = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
        r = sp[127:64];
      end else if (o[1:0] == 2'b10) begin
        sp = $signed({{64{a[63]}}, a}) * $signed({64'd0, b});
        r = sp[127:64];
      end else begin
        up = {64'd0, a} * {64'd0, b};
        r = up[127:64];
      end
    end else begin
      if (b == 0) r = o[1] ? a : ONES;
      else if (!o[0] && a == MIN64 && b == ONES) r = o[1] ? 64'd0 : a;
      else if (o[1:0] == 2'b00) r = sa / sb;
      else if (o[1:0] == 2'b01) r = a / b;
      else if (o[1:0] == 2'b10) r = sa % sb;
      else r = a % b;
    end
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic w,
    input logic [63:0] a, input logic [63:0] b);
    logic z;
    logic v;
    if (!o[2]) return w ? MLATW : MLAT;
    z = w ? (b[31:0] == 0) : (b == 0);
    v = !o[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                    : (a == MIN64 && b == ONES));
    if (z || v) return 1;
    return w ? 32 : 64;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return ONES;
      2: return MIN64;
      3: return 64'($urandom_range(0, 20));
      4: return {$urandom, 32'h8000_0000};
      5: return {$urandom, 32'hFFFF_FFFF};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic w,
                       input logic [63:0] x, input logic [63:0] y);
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    op = o;
    word = w;
    src1 = x;
    src2 = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 300);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_drop", 64'(out_valid), 64'd0);
  endtask

  task automatic run(input string nm, input logic [2:0] o, input logic w,
                     input logic [63:0] x, input logic [63:0] y,
                     input logic [63:0] er, input int el);
    int n;
    issue(o, w, x, y);
    wait_valid(n);
    chk({nm, "_lat"}, 64'(n), 64'(el));
    chk({nm, "_res"}, result, er);
    consume();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic seen;
    logic [2:0]  ro;
    logic        rw;
    logic [63:0] ra;
    logic [63:0] rb;

    tv[0]  = '{"mul", MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
               64'hFFFF_FFFF_FFFF_FFEB, MLAT};
    tv[1]  = '{"mulhu", MULHU, 1'b0, ONES, ONES,
               64'hFFFF_FFFF_FFFF_FFFE, MLAT};
    tv[2]  = '{"mulh", MULH, 1'b0, ONES, ONES, 64'd0, MLAT};
    tv[3]  = '{"div", DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 64};
    tv[4]  = '{"rem", REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 64};
    tv[5]  = '{"divuw", DIVU, 1'b1, 64'h1_0000_0010, 64'd4, 64'd4, 32};
    tv[6]  = '{"div0", DIV, 1'b0, 64'd5, 64'd0, ONES, 1};
    tv[7]  = '{"rem0", REM, 1'b0, 64'd5, 64'd0, 64'd5, 1};
    tv[8]  = '{"divovf", DIV, 1'b0, MIN64, ONES, MIN64, 1};
    tv[9]  = '{"removf", REM, 1'b0, MIN64, ONES, 64'd0, 1};
    tv[10] = '{"mulhsu", MULHSU, 1'b0, ONES, 64'd2, ONES, MLAT};
    tv[11] = '{"mulw", MUL, 1'b1, 64'h7FFF_FFFF, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFE, MLATW};
    tv[12] = '{"divwovf", DIV, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 1};
    tv[13] = '{"remuw0", REMU, 1'b1, 64'hFFFF_FFFF_8000_0007, 64'd0,
               64'hFFFF_FFFF_8000_0007, 1};
    tv[14] = '{"divu", DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 64};
    tv[15] = '{"remw", REM, 1'b1, 64'hFFFF_FFF9, 64'd2, ONES, 32};

    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = '0;
    word = 1'b0;
    src1 = '0;
    src2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_result", result, 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 16; i++)
      run(tv[i].nm, tv[i].op, tv[i].w, tv[i].a, tv[i].b,
          tv[i].res, tv[i].lat);

    // Result held in DONE, then back-to-back request.
    issue(MUL, 1'b0, 64'd3, 64'd5);
    wait_valid(n);
    chk("hold_lat", 64'(n), 64'(MLAT));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_result", result, 64'd15);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    op = MUL;
    word = 1'b0;
    src1 = 64'd6;
    src2 = 64'd7;
    @(posedge clk);
    #1;
    chk("b2b_valid_drop", 64'(out_valid), 64'd0);
    chk("b2b_not_busy", 64'(busy), 64'd0);
    chk("b2b_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("b2b_accept", 64'(busy), 64'd1);
    wait_valid(n);
    chk("b2b_lat", 64'(n), 64'(MLAT));
    chk("b2b_res", result, 64'd42);
    consume();

    // Flush mid-CALC.
    issue(DIV, 1'b0, 64'd1000000007, 64'd13);
    repeat (19) @(posedge clk);
    @(negedge clk);
    chk("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_idle", 64'(busy), 64'd0);
    chk("flush_no_valid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_pulse", 64'(seen), 64'd0);
    run("after_flush", DIVU, 1'b0, 64'd1000, 64'd7, 64'd142, 64);

    // Flush blocks accept in IDLE.
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    op = DIV;
    src1 = 64'd9;
    src2 = 64'd0;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_no_accept", 64'(busy), 64'd0);

    // Flush together with out_ready drops the result.
    issue(DIVU, 1'b0, 64'd77, 64'd0);
    wait_valid(n);
    chk("fo_lat", 64'(n), 64'd1);
    @(negedge clk);
    flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    out_ready = 1'b0;
    chk("fo_valid", 64'(out_valid), 64'd0);
    chk("fo_busy", 64'(busy), 64'd0);

    // Reset mid-CALC.
    issue(MUL, 1'b0, 64'd11, 64'd13);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_result", result, 64'd0);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    run("after_rst", MUL, 1'b0, 64'd11, 64'd13, 64'd143, MLAT);

    for (int i = 0; i < 150; i++) begin
      ro = 3'($urandom_range(0, 7));
      rw = 1'($urandom_range(0, 1));
      ra = pick();
      rb = pick();
      run($sformatf("rnd%0d_op%0d_w%0d", i, ro, rw), ro, rw, ra, rb,
          ref_res(ro, rw, ra, rb), ref_lat(ro, rw, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/ysyx_22040125_mdu.md
Name: ysyx_22040125_mdu

Overview:
Iterative multiply/divide unit for the RV64 execute stage, implementing the RISC-V M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU plus W variants) beside the single-cycle ALU. It is parametrised in datapath width and takes operands through a valid/ready handshake. It computes one bit per cycle with a shift-add multiplier and a restoring divider, and holds its result until the consumer takes it.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64. W ops are supported only when XLEN==64.
CNT_W, 7, width of the iteration counter; must satisfy 2^CNT_W > XLEN.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  kill the in-flight op (pipeline redirect)
in_valid  input  1  op request valid
in_ready  output  1  unit can accept a request this cycle
op  input  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
word  input  1  W variant: 32-bit operation, result sign-extended to XLEN
src1  input  XLEN  rs1 operand
src2  input  XLEN  rs2 operand
out_valid  output  1  result valid
out_ready  input  1  consumer takes the result
result  output  XLEN  op result
busy  output  1  state != IDLE

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, result=0, busy=0, in_ready=1 after the reset edge.
- States: IDLE, CALC, DONE.
- in_ready = (state==IDLE) & ~flush. A request is accepted on an edge where in_valid & in_ready; op, word, src1 and src2 are captured on that edge.
- Width N per op: N = 32 if word, otherwise XLEN. W operands use src[31:0], sign-extended for signed ops and zero-extended for unsigned ops. W results are sign-extended from bit 31.
- word with op 001–011 executes as MULW.
- Signed ops:
  - operands are converted to magnitudes, the core runs unsigned, and the sign is fixed at DONE entry;
  - MULH/MULHSU negate the full 2N-bit product before selecting the high half;
  - quotient sign = sign1 ^ sign2; remainder sign = sign of dividend.
- Normal path: IDLE -> CALC on accept, with the counter set to N-1. Each CALC edge performs one step. The edge with counter==0 moves to DONE.
  - Accept on edge k gives out_valid high from edge k+N.
  - Latency: MUL 64 cycles, MULW/DIVW 32 cycles.
- Special cases go IDLE -> DONE directly on the accept edge, so out_valid is high from edge k+1:
  - DIV/DIVU by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (dividend = most-negative N-bit value, divisor = -1): quotient = dividend, remainder = 0.
- DONE:
  - result is stable and out_valid=1 until out_ready.
  - The edge with out_ready moves to IDLE and clears out_valid.
  - A new request cannot be accepted in the same cycle as out_ready; accept is possible the following cycle.
- flush, any state: the next edge moves to IDLE, clears out_valid, and discards the in-flight op. No accept occurs in a cycle where flush=1. flush and out_ready together still drop the result, and the consumer ignores it.
- rst mid-operation has the same effect as flush and also clears result to 0.
- MUL-family result selection: MUL = product[N-1:0]; MULH* = product[2N-1:N].
- Divide core: restoring, one quotient bit per cycle, N+1-bit partial remainder.

Optional Feature:
MDU_FAST_MUL_EN:
- Defined: all multiply ops use a single combinational N×N multiplier (signed via sign-extended 2N-bit operands). Accept goes IDLE -> DONE, so out_valid is high from edge k+1. Divide is unchanged.
- Undefined: multiply is iterative with latency N as above. The combinational multiplier is not synthesised.

Test Plan:
- Reset then MUL src1=7, src2=-3 (XLEN=64) -> out_valid at k+64, result=0xFFFF_FFFF_FFFF_FFEB; with MDU_FAST_MUL_EN, out_valid at k+1.
- MULHU src1=src2=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE; MULH with the same operands -> 0.
- DIV src1=-7, src2=2 -> 0xFFFF_FFFF_FFFF_FFFD; REM with the same operands -> 0xFFFF_FFFF_FFFF_FFFF; DIVUW src1=0x1_0000_0010, src2=4 -> 4 at k+32.
- DIV src2=0, src1=5 -> at k+1 result=all ones; REM -> 5. DIV src1=0x8000_0000_0000_0000, src2=-1 -> at k+1 result=0x8000_0000_0000_0000; REM -> 0.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and result stable, in_ready=0. Then out_ready=1 -> IDLE next edge, and the back-to-back request is accepted one cycle later.
- flush at CALC cycle 20 -> IDLE next edge with no out_valid pulse, and the next op's result is correct. rst asserted mid-CALC -> all outputs at reset values.
